log_exp_iter_ctrl: RTL

LOG_EXP_ITER_CTRL -- requirements
Module: log_exp_iter_ctrl

---
 rtl/log_exp_pkg.sv | 16 +
 rtl/log_exp_datapath.sv | 84 ++++++++
 rtl/log_exp_iter_ctrl.sv | 67 ++++++
 3 files changed

// File: rtl/log_exp_pkg.sv
// Shared op encoding, FSM state enum and default widths for the iterative log2/exp2 engine.
package log_exp_pkg;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 8;

  localparam logic OP_LOG2 = 1'b0;
  localparam logic OP_EXP2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/log_exp_datapath.sv
// Operand shifter, accumulator and exponent counter; one iteration per step_i cycle.
// Optional iteration counter (out_iters) under LOG_EXP_ITER_CNT_EN.
module log_exp_datapath
  import log_exp_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          op_i,
  input  logic [DW-1:0] data_i,
  output logic          term_o,
  output logic [DW-1:0] result_o
`ifdef LOG_EXP_ITER_CNT_EN
  ,
  output logic [CW-1:0] iters_o
`endif
);

  logic          op_q, op_d;
  logic [DW-1:0] opnd_q, opnd_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // log2 stops when the operand drains; exp2 stops on exhausted exponent or shifted-out one.
  assign term_o   = (op_q == OP_LOG2) ? (opnd_q == '0) : ((cnt_q == '0) || (acc_q == '0));
  assign result_o = acc_q;

  always_comb begin
    op_d   = op_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      op_d   = op_i;
      opnd_d = data_i;
      acc_d  = (op_i == OP_EXP2) ? DW'(1) : '0;
      cnt_d  = (op_i == OP_EXP2) ? data_i[CW-1:0] : '0;
    end else if (step_i) begin
      if (op_q == OP_LOG2) begin
        opnd_d = opnd_q >> 1;
        acc_d  = DW'(acc_q[CW-1:0] + CW'(1));
      end else begin
        acc_d  = acc_q << 1;
        cnt_d  = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_LOG2;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      op_q   <= op_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef LOG_EXP_ITER_CNT_EN
  logic [CW-1:0] iters_q, iters_d;

  always_comb begin
    iters_d = iters_q;
    if (load_i)      iters_d = '0;
    else if (step_i) iters_d = iters_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) iters_q <= '0;
    else     iters_q <= iters_d;
  end

  assign iters_o = iters_q;
`endif

endmodule

// File: rtl/log_exp_iter_ctrl.sv
// Iterative log2 (bit-length) / exp2 engine: IDLE->RUN->DONE handshake FSM, result k+1 cycles after accept.
// One request at a time; result held in DONE until out_ready. LOG_EXP_ITER_CNT_EN adds out_iters.
module log_exp_iter_ctrl
  import log_exp_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_op,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
`ifdef LOG_EXP_ITER_CNT_EN
  ,
  output logic [CW-1:0] out_iters
`endif
);

  state_e state_q, state_d;
  logic   load, step, term;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign load      = in_ready && in_valid;
  assign step      = (state_q == RUN) && !term;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (term)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  log_exp_datapath #(
    .DW(DW),
    .CW(CW)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
    .op_i     (in_op),
    .data_i   (in_data),
    .term_o   (term),
    .result_o (out_data)
`ifdef LOG_EXP_ITER_CNT_EN
    ,
    .iters_o  (out_iters)
`endif
  );

endmodule
